// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the multicycle RV32I datapath: decodes FSM state and opcode into enables and mux selects.
// Optional illegal-opcode trap (HALT state, halted flag) is compiled in with `define TRAP_ILLEGAL_EN.
module multicycle_ctrl (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   output logic       pcWrite,
   output logic       adrSrc,
   output logic       irWrite,
   output logic       memWrite,
   output logic       regWrite,
   output logic [1:0] resSrc,
   output logic [1:0] aluSrcA,
   output logic [1:0] aluSrcB,
   output logic [1:0] inmSrc,
   output logic [2:0] ALUcontrol,
   output logic [3:0] fsmState,
   output logic       halted
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_ALUWB    = 4'd7,
      S_EXECI    = 4'd8,
      S_JAL      = 4'd9,
      S_BEQ      = 4'd10
`ifdef TRAP_ILLEGAL_EN
      , S_HALT   = 4'd11
`endif
   } state_e;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'd0,
      ALUOP_SUB   = 2'd1,
      ALUOP_FUNCT = 2'd2
   } aluop_e;

   localparam logic [6:0] OP_LW    = 7'b0000011;
   localparam logic [6:0] OP_SW    = 7'b0100011;
   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_ITYPE = 7'b0010011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;

   state_e state_q, state_d;

   always_ff @(posedge clk) begin
      if (reset) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   // Next-state logic; undefined encodings fall back to FETCH.
   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXECR;
               OP_ITYPE:     state_d = S_EXECI;
               OP_JAL:       state_d = S_JAL;
               OP_BEQ:       state_d = S_BEQ;
`ifdef TRAP_ILLEGAL_EN
               default:      state_d = S_HALT;
`else
               default:      state_d = S_FETCH;
`endif
            endcase
         end
         S_MEMADR:   state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:  state_d = S_MEMWB;
         S_EXECR:    state_d = S_ALUWB;
         S_EXECI:    state_d = S_ALUWB;
         S_JAL:      state_d = S_ALUWB;
         S_MEMWB,
         S_MEMWRITE,
         S_ALUWB,
         S_BEQ:      state_d = S_FETCH;
`ifdef TRAP_ILLEGAL_EN
         S_HALT:     state_d = S_HALT;
`endif
         default:    state_d = S_FETCH;
      endcase
   end

   logic       pc_update;
   logic       branch;
   logic       ir_write_raw;
   logic       mem_write_raw;
   logic       reg_write_raw;
   aluop_e     alu_op;

   // Per-state Moore outputs; anything not set for a state stays 0.
   always_comb begin
      pc_update     = 1'b0;
      branch        = 1'b0;
      ir_write_raw  = 1'b0;
      mem_write_raw = 1'b0;
      reg_write_raw = 1'b0;
      adrSrc        = 1'b0;
      resSrc        = 2'b00;
      aluSrcA       = 2'b00;
      aluSrcB       = 2'b00;
      alu_op        = ALUOP_ADD;
      case (state_q)
         S_FETCH: begin
            adrSrc       = 1'b0;
            ir_write_raw = 1'b1;
            aluSrcA      = 2'b00;
            aluSrcB      = 2'b10;
            alu_op       = ALUOP_ADD;
            resSrc       = 2'b10;
            pc_update    = 1'b1;
         end
         S_DECODE: begin
            aluSrcA = 2'b01;
            aluSrcB = 2'b01;
            alu_op  = ALUOP_ADD;
         end
         S_MEMADR: begin
            aluSrcA = 2'b10;
            aluSrcB = 2'b01;
            alu_op  = ALUOP_ADD;
         end
         S_MEMREAD: begin
            resSrc = 2'b00;
            adrSrc = 1'b1;
         end
         S_MEMWB: begin
            resSrc        = 2'b01;
            reg_write_raw = 1'b1;
         end
         S_MEMWRITE: begin
            resSrc        = 2'b00;
            adrSrc        = 1'b1;
            mem_write_raw = 1'b1;
         end
         S_EXECR: begin
            aluSrcA = 2'b10;
            aluSrcB = 2'b00;
            alu_op  = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            resSrc        = 2'b00;
            reg_write_raw = 1'b1;
         end
         S_EXECI: begin
            aluSrcA = 2'b10;
            aluSrcB = 2'b01;
            alu_op  = ALUOP_FUNCT;
         end
         S_JAL: begin
            // PC takes the DECODE-computed target from ALUOut while the ALU forms oldPC+4 for rd.
            aluSrcA   = 2'b01;
            aluSrcB   = 2'b10;
            alu_op    = ALUOP_ADD;
            resSrc    = 2'b00;
            pc_update = 1'b1;
         end
         S_BEQ: begin
            aluSrcA = 2'b10;
            aluSrcB = 2'b00;
            alu_op  = ALUOP_SUB;
            branch  = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      ALUcontrol = 3'b000;
      case (alu_op)
         ALUOP_ADD: ALUcontrol = 3'b000;
         ALUOP_SUB: ALUcontrol = 3'b001;
         ALUOP_FUNCT: begin
            case (funct3)
               // op[5] separates R-type sub from I-type addi, which has no subtract form.
               3'b000:  ALUcontrol = (funct7b5 & op[5]) ? 3'b001 : 3'b000;
               3'b010:  ALUcontrol = 3'b101;
               3'b110:  ALUcontrol = 3'b011;
               3'b111:  ALUcontrol = 3'b010;
               default: ALUcontrol = 3'b000;
            endcase
         end
         default: ALUcontrol = 3'b000;
      endcase
   end

   always_comb begin
      inmSrc = 2'b00;
      case (op)
         OP_SW:   inmSrc = 2'b01;
         OP_BEQ:  inmSrc = 2'b10;
         OP_JAL:  inmSrc = 2'b11;
         default: inmSrc = 2'b00;
      endcase
   end

   // Write enables are masked during reset so an aborted instruction leaves no partial write.
   assign pcWrite  = ~reset & (pc_update | (branch & zero));
   assign irWrite  = ~reset & ir_write_raw;
   assign memWrite = ~reset & mem_write_raw;
   assign regWrite = ~reset & reg_write_raw;
   assign fsmState = state_q;

`ifdef TRAP_ILLEGAL_EN
   assign halted = (state_q == S_HALT);
`else
   assign halted = 1'b0;
`endif

endmodule
